// File: rtl/mul2_accum.sv
// mul2_accum: sums a burst of LEN 4-bit products into an ACC_W-bit accumulator and
// presents the result with a sticky overflow flag over a valid/ready handshake.
// Optional build macro MUL2_ACCUM_SATURATE_EN: saturate at all ones instead of wrapping.
module mul2_accum #(
    parameter int unsigned ACC_W = 8,
    parameter int unsigned LEN   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       prod,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             overflow,
    output logic             busy
);

    localparam int unsigned CntW = $clog2(LEN + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(LEN - 1);

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic            ovf_q, ovf_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [ACC_W:0]  sum;

    // One extra bit catches the carry out of the accumulator.
    assign sum = {1'b0, acc_q} + {{(ACC_W - 3){1'b0}}, prod};

    // Next-state logic: burst sequencing and accumulation.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StAccum;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            StAccum: begin
                if (in_valid) begin
                    cnt_d = cnt_q + 1'b1;
                    if (sum[ACC_W]) begin
                        ovf_d = 1'b1;
`ifdef MUL2_ACCUM_SATURATE_EN
                        acc_d = '1;
`else
                        acc_d = sum[ACC_W-1:0];
`endif
                    end else begin
                        acc_d = sum[ACC_W-1:0];
                    end
                    if (cnt_q == LastCnt) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are decoded purely from registered state.
    always_comb begin
        in_ready  = (state_q == StAccum);
        out_valid = (state_q == StDone);
        busy      = (state_q != StIdle);
        acc_out   = acc_q;
        overflow  = ovf_q;
    end

endmodule

// File: doc/mul2_accum.md
Name: mul2_accum

Overview:
- Downstream stage of the 2-bit multiplier; consumes its 4-bit product P over a valid/ready handshake.
- Sums a burst of LEN products into an ACC_W-bit accumulator.
- Presents the sum with a sticky overflow flag over an output valid/ready handshake.
- Used for dot-product style sums of 2-bit operand pairs.

Parameters:
- ACC_W, 8, accumulator/result width in bits; legal range 4..16.
- LEN, 4, products per burst; legal range 1..255; counter width is $clog2(LEN+1).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset; asserts immediately, deassertion is synchronous to clk.
- start  input  1  one-cycle pulse that begins a burst; honoured only in IDLE.
- in_valid  input  1  prod is valid this cycle.
- in_ready  output  1  block accepts prod this cycle.
- prod  input  4  product from the multiplier, unsigned 0..9.
- out_valid  output  1  acc_out and overflow are valid.
- out_ready  input  1  consumer takes the result.
- acc_out  output  ACC_W  accumulated sum.
- overflow  output  1  sticky; set if any addition in the burst exceeded 2^ACC_W-1.
- busy  output  1  high in ACCUM or DONE.

Behaviour:
- Reset values: in_ready=0, out_valid=0, acc_out=0, overflow=0, busy=0, cnt=0, state=IDLE.
- All outputs are decoded from registered state or are registers. There is no combinational path from inputs to outputs.
- State IDLE:
  - in_ready=0, out_valid=0.
  - start=1 -> next state ACCUM; acc<=0, overflow<=0, cnt<=0.
- State ACCUM:
  - in_ready=1, busy=1.
  - A transfer happens when in_valid&&in_ready.
  - On a transfer: acc<=acc+{0,prod}, computed ACC_W+1 bits wide.
  - If bit ACC_W of that sum is 1: overflow<=1 and acc takes the low ACC_W bits (wrap).
  - On a transfer: cnt<=cnt+1.
  - The transfer where cnt==LEN-1 -> next state DONE. The last product is included in acc.
  - in_valid=0 -> hold all state; stalls of any length are allowed.
- State DONE:
  - out_valid=1, in_ready=0, busy=1. acc_out and overflow are stable while out_valid=1 and out_ready=0.
  - out_valid&&out_ready -> next state IDLE. acc_out keeps its value in IDLE until the next start.
- Latency: out_valid rises on the cycle after the LEN-th accepted product.
- start behaviour:
  - start is ignored in ACCUM and DONE.
  - start in the same cycle as the DONE->IDLE handshake is ignored; a new start is required in IDLE.
- Input range:
  - prod values 10..15 are never produced by the multiplier.
  - They are still added arithmetically with no special handling.
- LEN=1: a single transfer goes straight to DONE.
- Reset mid-operation: asynchronous return to IDLE with all reset values. A partial sum is discarded.

Optional Feature:
- Macro: MUL2_ACCUM_SATURATE_EN.
- Defined: when the ACC_W+1-bit sum has bit ACC_W set, acc<=all ones (2^ACC_W-1) and stays saturated for the rest of the burst. overflow is still set sticky.
- Not defined: wrap-around modulo 2^ACC_W as described in Behaviour.
- Port list is identical in both builds.

Test Plan:
- Basic burst:
  - Setup: ACC_W=8, LEN=4; start, then prod 9,6,4,1 on consecutive cycles with in_valid=1 and out_ready=1.
  - Required: out_valid one cycle after the 4th transfer, acc_out=20, overflow=0, then IDLE with busy=0.
- Stalls and backpressure:
  - Stimulus: same products with in_valid gaps of 0..3 cycles; out_ready held 0 for 5 cycles in DONE.
  - Required: acc_out=20, stable with out_valid=1 through the stall; no extra transfers accepted, in_ready=0 in DONE.
- Overflow, wrap build:
  - Setup: ACC_W=5, LEN=4; prod 9,9,9,9.
  - Required: acc_out=4 (36 mod 32), overflow=1.
  - With MUL2_ACCUM_SATURATE_EN defined: acc_out=31, overflow=1.
- Ignored start:
  - Stimulus: start pulses during ACCUM and during DONE.
  - Required: cnt and acc unaffected, result as in the basic burst.
  - Stimulus: start coincident with the output handshake.
  - Required: block sits in IDLE; a second start begins a new burst with acc=0 and overflow=0.
- Reset mid-burst:
  - Stimulus: rst_n low for 1 cycle after 2 transfers (9,6), then a fresh burst 1,1,1,1.
  - Required: all outputs 0 immediately on rst_n low; next result acc_out=4, overflow=0.
- LEN=1:
  - Stimulus: start, prod 9.
  - Required: out_valid on the next cycle, acc_out=9.
